// File: rtl/uldl_pkg.sv
// uldl_pkg: shared types and constants for the UL/DL packet serializer.
// Frame layout is {dir, id[7:0], parity}, transmitted MSB first.
package uldl_pkg;

    localparam int   FRAME_LEN = 10;
    localparam logic DIR_UL    = 1'b0;
    localparam logic DIR_DL    = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic       dir;
        logic [7:0] id;
    } fifo_entry_t;

    // Even parity covers the direction bit and all eight ID bits.
    function automatic logic [FRAME_LEN-1:0] build_frame(input fifo_entry_t e);
        return {e.dir, e.id, ^{e.dir, e.id}};
    endfunction

endpackage

// File: rtl/uldl_sync_fifo.sv
// uldl_sync_fifo: register-based synchronous FIFO. A push while full is
// accepted when a pop frees the head entry in the same cycle.
module uldl_sync_fifo
    import uldl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  fifo_entry_t            i_wdata,
    output fifo_entry_t            o_rdata,
    output logic                   o_empty,
    output logic                   o_push_ok,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [$clog2(DEPTH):0] o_level_d
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full, pop_ok;

    assign full      = (level_q == LVL_FULL);
    assign o_empty   = (level_q == '0);
    assign pop_ok    = i_pop && !o_empty;
    assign o_push_ok = i_push && (!full || pop_ok);
    assign o_rdata   = mem_q[rd_ptr_q];
    assign o_level   = level_q;
    assign o_level_d = level_d;

    always_comb begin
        level_d = level_q;
        if (o_push_ok && !pop_ok)
            level_d = level_q + LVL_ONE;
        else if (pop_ok && !o_push_ok)
            level_d = level_q - LVL_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (o_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)    rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Storage is data only; pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (o_push_ok) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/uldl_packet_serializer.sv
// uldl_packet_serializer: buffers generator packets and emits each as a 10-bit
// serial frame. Per-direction frame statistics exist only with ULDL_STATS_EN.
module uldl_packet_serializer
    import uldl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ena,
    input  logic [7:0]             i_packet_id,
    input  logic                   i_dir_dl,
    input  logic                   i_packet_pulse,
    output logic                   o_ser_data,
    output logic                   o_ser_valid,
    output logic                   o_frame_start,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_fifo_level,
    output logic [CNT_W-1:0]       o_drop_cnt,
    output logic [CNT_W-1:0]       o_ul_cnt,
    output logic [CNT_W-1:0]       o_dl_cnt
);
    localparam int         LW       = $clog2(DEPTH) + 1;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e               state_q, state_d;
    logic [3:0]           bit_cnt_q;
    logic [FRAME_LEN-1:0] sreg_q, load_frame;
    logic                 ser_data_q, ser_valid_q, frame_start_q, busy_q;
    logic [CNT_W-1:0]     drop_cnt_q;
    fifo_entry_t          wr_entry, rd_entry;
    logic                 push, push_ok, pop, fifo_empty, last_bit;
    logic [LW-1:0]        fifo_level, fifo_level_d;

    assign wr_entry   = '{dir: i_dir_dl, id: i_packet_id};
    assign push       = i_ena & i_packet_pulse;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign last_bit   = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign load_frame = build_frame(rd_entry);

    uldl_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (push),
        .i_pop     (state_q == ST_IDLE),
        .i_wdata   (wr_entry),
        .o_rdata   (rd_entry),
        .o_empty   (fifo_empty),
        .o_push_ok (push_ok),
        .o_level   (fifo_level),
        .o_level_d (fifo_level_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty)              state_d = ST_SHIFT;
            ST_SHIFT: if (bit_cnt_q == LAST_BIT)    state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // Bit 0 is registered straight from the loaded frame so it appears the cycle after the pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            ser_data_q    <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE) || (fifo_level_d != '0);
            if (push && !push_ok) drop_cnt_q <= sat_inc(drop_cnt_q);
            if (state_q == ST_IDLE) begin
                bit_cnt_q     <= '0;
                frame_start_q <= pop;
                ser_valid_q   <= pop;
                ser_data_q    <= pop & load_frame[FRAME_LEN-1];
            end else begin
                frame_start_q <= 1'b0;
                ser_valid_q   <= !last_bit;
                ser_data_q    <= !last_bit & sreg_q[FRAME_LEN-1];
                bit_cnt_q     <= last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (pop)
            sreg_q <= {load_frame[FRAME_LEN-2:0], 1'b0};
        else if (state_q == ST_SHIFT)
            sreg_q <= {sreg_q[FRAME_LEN-2:0], 1'b0};
    end

`ifdef ULDL_STATS_EN
    logic             dir_q;
    logic [CNT_W-1:0] ul_cnt_q, dl_cnt_q;

    always_ff @(posedge i_clk) begin
        if (pop) dir_q <= rd_entry.dir;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ul_cnt_q <= '0;
            dl_cnt_q <= '0;
        end else if (last_bit) begin
            if (dir_q == DIR_DL) dl_cnt_q <= sat_inc(dl_cnt_q);
            else                 ul_cnt_q <= sat_inc(ul_cnt_q);
        end
    end

    assign o_ul_cnt = ul_cnt_q;
    assign o_dl_cnt = dl_cnt_q;
`else
    assign o_ul_cnt = '0;
    assign o_dl_cnt = '0;
`endif

    assign o_ser_data    = ser_data_q;
    assign o_ser_valid   = ser_valid_q;
    assign o_frame_start = frame_start_q;
    assign o_busy        = busy_q;
    assign o_fifo_level  = fifo_level;
    assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_uldl_packet_serializer.sv
// Directed bench for uldl_packet_serializer: a default instance plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_uldl_packet_serializer;

`ifdef ULDL_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, ena = 1'b1, dir = 1'b0, pulse = 1'b0;
    logic [7:0] pid = 8'h00;

    logic       ser_data, ser_valid, frame_start, busy;
    logic [2:0] level;
    logic [7:0] drop, ul, dl;

    logic       s_ser_data, s_ser_valid, s_frame_start, s_busy;
    logic [2:0] s_level;
    logic [1:0] s_drop, s_ul, s_dl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uldl_packet_serializer #(.DEPTH(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_packet_id(pid), .i_dir_dl(dir),
        .i_packet_pulse(pulse), .o_ser_data(ser_data), .o_ser_valid(ser_valid),
        .o_frame_start(frame_start), .o_busy(busy), .o_fifo_level(level),
        .o_drop_cnt(drop), .o_ul_cnt(ul), .o_dl_cnt(dl)
    );

    uldl_packet_serializer #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_packet_id(pid), .i_dir_dl(dir),
        .i_packet_pulse(pulse), .o_ser_data(s_ser_data), .o_ser_valid(s_ser_valid),
        .o_frame_start(s_frame_start), .o_busy(s_busy), .o_fifo_level(s_level),
        .o_drop_cnt(s_drop), .o_ul_cnt(s_ul), .o_dl_cnt(s_dl)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pulse = 1'b0; ena = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a frame start, then records ten bits; ok drops if
    // valid/frame_start misbehave or no frame appears.
    task automatic capture_frame(input int max_wait, output logic [9:0] bits,
                                 output int waited, output logic ok);
        waited = 0; ok = 1'b1; bits = '0;
        while (frame_start !== 1'b1 && waited < max_wait) begin
            step(); waited++;
        end
        if (frame_start !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        for (int i = 0; i < 10; i++) begin
            if (ser_valid !== 1'b1 || frame_start !== (i == 0)) ok = 1'b0;
            bits[9-i] = ser_data;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++; if ({ser_data, ser_valid, frame_start, busy} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {ser_data, ser_valid, frame_start, busy}); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if ({drop, ul, dl} !== 24'h0) begin bad++; $display("FAIL reset_cnts: got %h want 000000", {drop, ul, dl}); end
        total++; if ({s_ser_data, s_ser_valid, s_frame_start, s_busy, s_level, s_drop, s_ul, s_dl} !== 13'h0) begin bad++; $display("FAIL reset_sat_inst: got %h want 0", {s_ser_data, s_ser_valid, s_frame_start, s_busy, s_level, s_drop, s_ul, s_dl}); end
        rst = 1'b0;
        step();
        total++; if ({ser_valid, busy} !== 2'b00) begin bad++; $display("FAIL reset_idle: got %b want 00", {ser_valid, busy}); end
    endtask

    task automatic test_single_ul();
        logic [9:0] bits; int w; logic ok;
        do_reset();
        pulse = 1'b1; pid = 8'hA5; dir = 1'b0;
        step();
        pulse = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ul_busy: got %b want 1", busy); end
        capture_frame(5, bits, w, ok);
        total++; if (w != 1) begin bad++; $display("FAIL ul_latency: got %0d want 1", w); end
        total++; if (!ok) begin bad++; $display("FAIL ul_shape: got 0 want 1"); end
        total++; if (bits !== 10'b0101001010) begin bad++; $display("FAIL ul_bits: got %b want 0101001010", bits); end
        total++; if ({ser_valid, ser_data, busy} !== 3'b000) begin bad++; $display("FAIL ul_after: got %b want 000", {ser_valid, ser_data, busy}); end
        total++; if (ul !== 8'(STATS) || dl !== 8'd0) begin bad++; $display("FAIL ul_cnt: got ul=%0d dl=%0d want ul=%0d dl=0", ul, dl, STATS); end
    endtask

    task automatic test_single_dl();
        logic [9:0] bits; int w; logic ok;
        do_reset();
        pulse = 1'b1; pid = 8'h3C; dir = 1'b1;
        step();
        pulse = 1'b0;
        capture_frame(5, bits, w, ok);
        total++; if (w != 1 || !ok) begin bad++; $display("FAIL dl_timing: got wait=%0d ok=%b want wait=1 ok=1", w, ok); end
        total++; if (bits !== 10'b1001111001) begin bad++; $display("FAIL dl_bits: got %b want 1001111001", bits); end
        total++; if (bits[0] !== 1'b1) begin bad++; $display("FAIL dl_parity: got %b want 1", bits[0]); end
        total++; if (dl !== 8'(STATS) || ul !== 8'd0) begin bad++; $display("FAIL dl_cnt: got dl=%0d ul=%0d want dl=%0d ul=0", dl, ul, STATS); end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_bits [5];
        exp_bits = '{10'b0000100001, 10'b1000100011, 10'b0000100100,
                     10'b1000100110, 10'b0000101000};
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    pulse = 1'b1; pid = 8'(16 + i); dir = i[0];
                    step();
                end
                pulse = 1'b0;
                total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", level); end
                total++; if (drop !== 8'd1 || s_drop !== 2'd1) begin bad++; $display("FAIL ovf_drop: got %0d/%0d want 1/1", drop, s_drop); end
            end
            begin
                logic [9:0] bits; int w; logic ok;
                for (int f = 0; f < 5; f++) begin
                    capture_frame(20, bits, w, ok);
                    total++; if (w != ((f == 0) ? 2 : 1) || !ok) begin bad++; $display("FAIL ovf_gap%0d: got wait=%0d ok=%b want wait=%0d ok=1", f, w, ok, (f == 0) ? 2 : 1); end
                    total++; if (bits !== exp_bits[f]) begin bad++; $display("FAIL ovf_bits%0d: got %b want %b", f, bits, exp_bits[f]); end
                end
            end
        join
        total++; if ({busy, level} !== 4'h0) begin bad++; $display("FAIL ovf_drain: got busy=%b level=%0d want 0/0", busy, level); end
        total++; if (ul !== 8'(3 * STATS) || dl !== 8'(2 * STATS)) begin bad++; $display("FAIL ovf_stats: got ul=%0d dl=%0d want %0d/%0d", ul, dl, 3 * STATS, 2 * STATS); end
    endtask

    task automatic test_ena_gating();
        do_reset();
        ena = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pulse = (i % 3 == 0); pid = 8'hFF; dir = 1'b1;
            step();
            total++; if (ser_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL ena_cycle%0d: got valid=%b level=%0d want 0/0", i, ser_valid, level); end
        end
        pulse = 1'b0; ena = 1'b1;
        total++; if (drop !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL ena_drop: got drop=%0d busy=%b want 0/0", drop, busy); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits; int w; logic ok;
        do_reset();
        pulse = 1'b1; pid = 8'hA5; dir = 1'b0;
        step();
        pulse = 1'b0;
        for (int i = 0; i < 5; i++) step();
        total++; if (ser_valid !== 1'b1 || frame_start !== 1'b0) begin bad++; $display("FAIL mid_bit4: got valid=%b start=%b want 1/0", ser_valid, frame_start); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({ser_data, ser_valid, frame_start, busy, level} !== 7'h0) begin bad++; $display("FAIL mid_outputs: got %b want 0", {ser_data, ser_valid, frame_start, busy, level}); end
        total++; if ({drop, ul, dl} !== 24'h0) begin bad++; $display("FAIL mid_cnts: got %h want 000000", {drop, ul, dl}); end
        pulse = 1'b1; pid = 8'h3C; dir = 1'b1;
        step();
        pulse = 1'b0;
        capture_frame(5, bits, w, ok);
        total++; if (w != 1 || !ok || bits !== 10'b1001111001) begin bad++; $display("FAIL mid_refresh: got wait=%0d ok=%b bits=%b want 1/1/1001111001", w, ok, bits); end
        total++; if (dl !== 8'(STATS) || ul !== 8'd0) begin bad++; $display("FAIL mid_stats: got dl=%0d ul=%0d want %0d/0", dl, ul, STATS); end
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pulse = 1'b1; pid = 8'(i); dir = 1'b0;
            step();
        end
        pulse = 1'b0;
        total++; if (drop !== 8'd5) begin bad++; $display("FAIL sat_drop8: got %0d want 5", drop); end
        total++; if (s_drop !== 2'd3) begin bad++; $display("FAIL sat_drop2: got %0d want 3", s_drop); end
        n = 0;
        while (busy !== 1'b0 && n < 200) begin step(); n++; end
        total++; if (busy !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL sat_drain: got busy=%b level=%0d after %0d cycles want 0/0", busy, level, n); end
        total++; if (s_drop !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d want 3", s_drop); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single_ul();
        test_single_dl();
        test_overflow();
        test_ena_gating();
        test_reset_midframe();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
